// File: rtl/novelty_report_framer.sv
// Buffers novelty engine results in a small FIFO and serialises each one as a
// 7-byte frame (SYNC, SEQ, E_HI, E_LO, WEIGHT, FLAGS, CSUM) over the uart_tx start/busy handshake.
module novelty_report_framer #(
  parameter int         DEPTH = 4,
  parameter logic [7:0] SYNC  = 8'hA5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sample_valid,
  input  logic [15:0]              energy,
  input  logic [7:0]               weight,
  input  logic                     novel,
  input  logic                     tx_busy,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [7:0]               drop_count,
  output logic                     frame_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, SEND, GUARD, WAIT} state_t;

  state_t          r_state;
  state_t          w_nextState;

  logic [24:0]     r_mem [DEPTH];
  logic [AW-1:0]   r_wrPtr;
  logic [AW-1:0]   r_rdPtr;
  logic [LW-1:0]   r_level;
  logic            r_ovf;
  logic [7:0]      r_dropCount;

  logic [15:0]     r_energy;
  logic [7:0]      r_weight;
  logic [1:0]      r_flags;
  logic [7:0]      r_seq;
  logic [7:0]      r_csum;
  logic [2:0]      r_idx;

  logic            r_txStart;
  logic [7:0]      r_txData;
  logic            r_frameDone;

  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic            w_issue;
  logic [2:0]      w_issueIdx;
  logic [7:0]      w_byte;
  logic [24:0]     w_head;

  assign w_head = r_mem[r_rdPtr];
  assign w_pop  = (r_state == IDLE) && (r_level != '0);
  assign w_push = sample_valid && ((r_level < LW'(DEPTH)) || w_pop);
  assign w_drop = sample_valid && !w_push;

  // Strobes are registered, so the issue decision is taken one cycle ahead:
  // tx_busy can only rise after our own start, so a low busy stays low until the strobe lands.
  always_comb begin
    w_nextState = r_state;
    w_issue     = 1'b0;
    w_issueIdx  = r_idx;
    case (r_state)
      IDLE: begin
        if (w_pop) begin
          w_issueIdx = 3'd0;
          if (!tx_busy) begin
            w_issue     = 1'b1;
            w_nextState = GUARD;
          end else begin
            w_nextState = SEND;
          end
        end
      end
      SEND: begin
        if (!tx_busy) begin
          w_issue     = 1'b1;
          w_nextState = GUARD;
        end
      end
      GUARD: w_nextState = WAIT;
      WAIT: begin
        if (!tx_busy) begin
          if (r_idx == 3'd6) begin
            w_nextState = IDLE;
          end else begin
            w_issue     = 1'b1;
            w_issueIdx  = r_idx + 3'd1;
            w_nextState = GUARD;
          end
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_byte = 8'h00;
    case (w_issueIdx)
      3'd0:    w_byte = SYNC;
      3'd1:    w_byte = r_seq;
      3'd2:    w_byte = r_energy[15:8];
      3'd3:    w_byte = r_energy[7:0];
      3'd4:    w_byte = r_weight;
      3'd5:    w_byte = {6'b0, r_flags};
      3'd6:    w_byte = r_csum;
      default: w_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= 3'd0;
    end else begin
      r_state <= w_nextState;
      r_idx   <= w_issueIdx;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= {novel, weight, energy};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_level     <= '0;
      r_ovf       <= 1'b0;
      r_dropCount <= 8'h00;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + AW'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + AW'(1);
      if (w_push && !w_pop)      r_level <= r_level + LW'(1);
      else if (w_pop && !w_push) r_level <= r_level - LW'(1);
      // A drop coinciding with the pop must survive into the next frame's flags.
      if (w_drop)     r_ovf <= 1'b1;
      else if (w_pop) r_ovf <= 1'b0;
      if (w_drop && (r_dropCount != 8'hFF)) r_dropCount <= r_dropCount + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_energy    <= 16'h0000;
      r_weight    <= 8'h00;
      r_flags     <= 2'b00;
      r_seq       <= 8'h00;
      r_csum      <= 8'h00;
      r_txStart   <= 1'b0;
      r_txData    <= 8'h00;
      r_frameDone <= 1'b0;
    end else begin
      if (w_pop) begin
        r_energy <= w_head[15:0];
        r_weight <= w_head[23:16];
        r_flags  <= {r_ovf, w_head[24]};
        r_csum   <= 8'h00;
      end else if (w_issue && (w_issueIdx != 3'd0) && (w_issueIdx != 3'd6)) begin
        r_csum <= r_csum ^ w_byte;
      end
      if (w_issue && (w_issueIdx == 3'd6)) r_seq <= r_seq + 8'd1;
      r_txStart   <= w_issue;
      r_frameDone <= w_issue && (w_issueIdx == 3'd6);
      if (w_issue) r_txData <= w_byte;
    end
  end

  assign tx_start   = r_txStart;
  assign tx_data    = r_txData;
  assign fifo_level = r_level;
  assign drop_count = r_dropCount;
  assign frame_done = r_frameDone;

endmodule

// File: tb/tb_novelty_report_framer.sv
// Randomised and directed bench for novelty_report_framer against a queue-based
// frame model with an arithmetic timing model of the start/busy handshake.
module tb_novelty_report_framer;

  localparam int         DEPTH = 4;
  localparam logic [7:0] SYNC  = 8'hA5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_valid = 1'b0;
  logic [15:0] energy = '0;
  logic [7:0]  weight = '0;
  logic        novel = 1'b0;
  logic        tx_busy = 1'b0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [2:0]  fifo_level;
  logic [7:0]  drop_count;
  logic        frame_done;

  always #5 clk = ~clk;

  novelty_report_framer #(.DEPTH(DEPTH), .SYNC(SYNC)) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid),
    .energy(energy), .weight(weight), .novel(novel), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_data(tx_data), .fifo_level(fifo_level),
    .drop_count(drop_count), .frame_done(frame_done)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // uart_tx stand-in plus an optional forced-busy window
  int busyLen = 2;
  int busyCnt = 0;
  int forceEnd = 0;

  // reference model
  logic [24:0] mq[$];
  int          mDrop = 0;
  bit          mOvf = 0;
  logic [7:0]  mSeq = 8'h00;
  int          freeAt = 0;
  int          startQ[$];
  logic [7:0]  byteQ[$];
  int          doneQ[$];
  logic [7:0]  expData = 8'h00;
  int          lastEHi = 0;
  int          pushed = 0;

  logic [7:0]  seenBytes[$];
  int          doneCount = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit sv, input logic [24:0] rec);
    logic [24:0] r;
    logic [7:0]  b [7];
    bit          pop;
    bit          startNow;
    bit          expStart;
    bit          expDone;
    int          sizeBefore;
    int          s0;
    reset        = rst;
    sample_valid = sv;
    {novel, weight, energy} = rec;
    if (rst) begin
      mq.delete(); startQ.delete(); byteQ.delete(); doneQ.delete();
      mDrop = 0; mOvf = 0; mSeq = 8'h00; freeAt = cyc + 1; expData = 8'h00;
    end else begin
      sizeBefore = mq.size();
      pop = (cyc >= freeAt) && (sizeBefore > 0);
      if (pop) begin
        r = mq.pop_front();
        b[0] = SYNC; b[1] = mSeq; b[2] = r[15:8]; b[3] = r[7:0];
        b[4] = r[23:16]; b[5] = {6'b0, mOvf, r[24]};
        b[6] = b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5];
        mOvf = 0;
        mSeq = mSeq + 8'd1;
        s0 = ((cyc > forceEnd) ? cyc : forceEnd) + 1;
        for (int k = 0; k < 7; k++) begin
          startQ.push_back(s0 + k * (busyLen + 2));
          byteQ.push_back(b[k]);
        end
        doneQ.push_back(s0 + 6 * (busyLen + 2));
        lastEHi = s0 + 2 * (busyLen + 2);
        freeAt = s0 + 7 * (busyLen + 2);
      end
      if (sv) begin
        if (sizeBefore < DEPTH || pop) begin
          mq.push_back(rec);
          pushed++;
        end else begin
          if (mDrop < 255) mDrop++;
          mOvf = 1;
        end
      end
    end
    startNow = (tx_start === 1'b1);
    @(posedge clk);
    if (startNow) busyCnt = busyLen;
    else if (busyCnt > 0) busyCnt--;
    #1;
    cyc++;
    tx_busy = (busyCnt > 0) || (cyc < forceEnd);
    expStart = (startQ.size() > 0) && (startQ[0] == cyc);
    checkOutput("tx_start", tx_start, expStart);
    if (expStart) begin
      expData = byteQ.pop_front();
      void'(startQ.pop_front());
    end
    checkOutput("tx_data", tx_data, expData);
    expDone = (doneQ.size() > 0) && (doneQ[0] == cyc);
    if (expDone) void'(doneQ.pop_front());
    checkOutput("frame_done", frame_done, expDone);
    checkOutput("fifo_level", fifo_level, mq.size());
    checkOutput("drop_count", drop_count, mDrop);
    if (tx_start === 1'b1) begin
      checkOutput("startWhileBusy", tx_busy, 1'b0);
      seenBytes.push_back(tx_data);
    end
    if (frame_done === 1'b1) doneCount++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, '0);
  endtask

  task automatic drain;
    int n = 0;
    while ((mq.size() > 0 || cyc < freeAt || busyCnt > 0 || startQ.size() > 0) && n < 5000) begin
      applyStimulus(0, 0, '0);
      n++;
    end
    checkOutput("drainBound", (n < 5000), 1'b1);
  endtask

  initial begin
    logic [7:0] golden [7];
    logic [4:0] ovfBits;

    applyStimulus(1, 0, '0);
    applyStimulus(1, 0, '0);
    idle(3);

    // single record, known frame bytes
    seenBytes.delete(); doneCount = 0; busyLen = 2;
    applyStimulus(0, 1, {1'b1, 8'h15, 16'h0123});
    drain();
    golden = '{8'hA5, 8'h00, 8'h01, 8'h23, 8'h15, 8'h01, 8'h36};
    checkOutput("t1Count", seenBytes.size(), 7);
    for (int k = 0; k < 7; k++)
      if (k < seenBytes.size()) checkOutput($sformatf("t1Byte%0d", k), seenBytes[k], golden[k]);
    checkOutput("t1Done", doneCount, 1);

    // overflow with the uart held busy
    seenBytes.delete();
    forceEnd = cyc + 30;
    for (int i = 0; i < 7; i++) applyStimulus(0, 1, 25'($urandom));
    idle(5);
    checkOutput("ovfDrop", drop_count, 8'd2);
    checkOutput("ovfLevel", fifo_level, 3'd4);
    drain();
    ovfBits = 5'b00010;
    checkOutput("ovfBytes", seenBytes.size(), 35);
    for (int i = 0; i < 5; i++)
      if (7 * i + 5 < seenBytes.size())
        checkOutput($sformatf("ovfFlag%0d", i), seenBytes[7 * i + 5][1], ovfBits[i]);

    // simultaneous push and pop while full
    busyLen = 20;
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 25'($urandom));
    while (cyc < freeAt) applyStimulus(0, 0, '0);
    checkOutput("fullPre", fifo_level, 3'd4);
    applyStimulus(0, 1, 25'($urandom));
    checkOutput("fullLevel", fifo_level, 3'd4);
    checkOutput("fullDrop", drop_count, 8'd2);
    drain();

    // 257 frames to wrap SEQ
    applyStimulus(1, 0, '0);
    seenBytes.delete(); busyLen = 1; pushed = 0;
    while (pushed < 257) applyStimulus(0, (mq.size() < 2), 25'($urandom));
    drain();
    checkOutput("wrapBytes", seenBytes.size(), 257 * 7);
    if (seenBytes.size() >= 257 * 7) begin
      checkOutput("seqFE", seenBytes[254 * 7 + 1], 8'hFE);
      checkOutput("seqFF", seenBytes[255 * 7 + 1], 8'hFF);
      checkOutput("seq00", seenBytes[256 * 7 + 1], 8'h00);
    end

    // slow uart, 115200 baud
    busyLen = 235;
    applyStimulus(0, 1, 25'($urandom));
    applyStimulus(0, 1, 25'($urandom));
    drain();

    // reset one cycle after the E_HI strobe with two records queued
    busyLen = 3;
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 25'($urandom));
    while (cyc < lastEHi + 1) applyStimulus(0, 0, '0);
    applyStimulus(1, 0, '0);
    checkOutput("rstStart", tx_start, 1'b0);
    checkOutput("rstData", tx_data, 8'h00);
    checkOutput("rstLevel", fifo_level, 3'd0);
    checkOutput("rstDone", frame_done, 1'b0);
    idle(20);
    seenBytes.delete();
    applyStimulus(0, 1, 25'($urandom));
    drain();
    checkOutput("rstFrame", seenBytes.size(), 7);
    if (seenBytes.size() >= 2) checkOutput("rstSeq", seenBytes[1], 8'h00);

    // random traffic with varying uart speed
    for (int batch = 0; batch < 4; batch++) begin
      busyLen = $urandom_range(1, 8);
      for (int i = 0; i < 300; i++) applyStimulus(0, ($urandom_range(0, 2) == 0), 25'($urandom));
      drain();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
